mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register; sits directly upstream of write-back.
//  Takes the EX/MEM bundle and issues loads and stores to a multi-cycle data memory (req/done handshake).
//  Stalls the upstream pipe until the access completes, then registers aluResult, readData,
//  nextPC, enJAL and mem_to_reg (plus reg-write control) for write-back.
//  Also detects misaligned accesses and latches halt.
// PARAMETERS
//  DW      16  data/address width
//  RW      3   register-specifier width
//  ALIGNCK 1   1: word accesses with addr[0]=1 flag err and are suppressed; 0: no check
// PORTS
//  clk            in  1   clock; all state updates on rising edge
//  rst            in  1   reset, asynchronous, active-high
//  ex_valid       in  1   EX/MEM slot holds a real instruction
//  ex_aluResult   in  DW  ALU result / memory address
//  ex_storeData   in  DW  store data
//  ex_nextPC      in  DW  PC+2 (JAL link value)
//  ex_memRead     in  1   load
//  ex_memWrite    in  1   store
//  ex_enJAL       in  1   link-write select
//  ex_mem_to_reg  in  1   load-data select
//  ex_regWrite    in  1   instruction writes the register file
//  ex_writeReg    in  RW  destination register
//  ex_halt        in  1   HALT instruction
//  mem_addr       out DW  = ex_aluResult (combinational)
//  mem_wdata      out DW  = ex_storeData (combinational)
//  mem_rd         out 1   load request, one-cycle pulse
//  mem_wr         out 1   store request, one-cycle pulse
//  mem_rdata      in  DW  load data; valid only while mem_done=1
//  mem_done       in  1   access complete; one-cycle pulse; may arrive in the request cycle
//  stall_out      out 1   hold EX/MEM and all upstream stages
//  wb_valid       out 1   WB slot valid
//  wb_aluResult, wb_readData, wb_nextPC  out DW  to write-back mux
//  wb_enJAL, wb_mem_to_reg, wb_regWrite  out 1   WB control
//  wb_writeReg    out RW
//  wb_halt        out 1   halt retired; sticky
//  err            out 1   misaligned access seen; sticky
// BEHAVIOUR
//  - Reset: every wb_* output, err, mem_rd and mem_wr = 0; FSM = IDLE.
//  - Definitions:
//    - acc = ex_valid & (ex_memRead|ex_memWrite) & ~halted & ~mis
//    - mis = ALIGNCK & ex_aluResult[0] & (ex_memRead|ex_memWrite)
//  - FSM IDLE:
//    - acc -> mem_rd=ex_memRead, mem_wr=ex_memWrite for this cycle only.
//    - If mem_done is not seen in the same cycle, go to WAIT.
//  - FSM WAIT:
//    - mem_rd = mem_wr = 0.
//    - On mem_done go to IDLE; otherwise stay in WAIT.
//  - stall_out = ((IDLE & acc) | WAIT) & ~mem_done.
//  - Upstream holds all ex_* stable while stall_out=1.
//  - WB register, each clk edge:
//    - stall_out=1 -> wb_valid <= 0 (bubble); other wb_* fields don't care.
//    - Else wb_valid <= ex_valid & ~halted, and the fields copy ex_*.
//    - wb_readData <= mem_rdata if the access completes this cycle with memRead, else 0.
//  - Latency:
//    - Non-memory op: 1 cycle.
//    - Zero-wait access (done in the request cycle): 1 cycle.
//    - k-cycle access: k+1 cycles, with k bubbles behind it.
//  - Misaligned: no mem request; retires with wb_regWrite=0 and wb_mem_to_reg=0; err <= 1.
//  - Halt:
//    - ex_valid & ex_halt & ~stall_out -> wb_halt <= 1 and halted <= 1.
//    - Thereafter all ex_valid is ignored (wb_valid = 0); cleared only by rst.
//  - Stray mem_done while IDLE with no acc: ignored; no state change.
//  - rst mid-access: FSM returns to IDLE; a late mem_done after reset is ignored; no re-issue.
//  - mem_rd and mem_wr are never both 1.
//    ex_memRead & ex_memWrite together is illegal; treat it as a load.
// STRUCTURE
//  - Shared defines include file: FSM state encodings (IDLE=1'b0, WAIT=1'b1) and DW/RW defaults.
//  - Sub-module mem_wb_latch: parameterised DW register bank with async reset and an enable/bubble input.
//    Instantiated once for the WB bundle.
//  - FSM, stall and misalign logic stay inline.
// TESTING
//  1. ALU op, ex_aluResult=16'h1234, regWrite=1, no mem
//     -> next edge: wb_valid=1, wb_aluResult=1234; stall_out never 1.
//  2. Load from addr 16'h0040, mem_done 3 cycles after mem_rd, mem_rdata=16'hBEEF
//     -> mem_rd exactly 1 cycle; stall_out=1 for 3 cycles; then wb_readData=BEEF, wb_mem_to_reg=1.
//  3. Store to 16'h0010, mem_done in request cycle
//     -> mem_wr 1 cycle; stall_out stays 0; wb_valid=1 next edge.
//  4. Load to 16'h0003 (ALIGNCK=1)
//     -> no mem_rd; err=1 sticky; wb_regWrite=0.
//  5. Assert rst in WAIT, then mem_done pulse after release
//     -> all outputs 0; FSM IDLE; pulse ignored; next ALU op retires normally.
//  6. JAL (enJAL=1, nextPC=16'h0102) then HALT then ALU op
//     -> wb_nextPC=0102; wb_halt=1; following op never sets wb_valid.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory stage: FSM state encodings and default widths.
package mem_wb_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned RW_DEF = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB register bank: async reset, bubble input clears the valid bit and holds the payload.
module mem_wb_latch #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic         validIn,
    input  logic [W-1:0] d,
    output logic         validOut,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validOut <= 1'b0;
            q        <= '0;
        end else if (bubble) begin
            validOut <= 1'b0;
        end else begin
            validOut <= validIn;
            q        <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage with req/done handshake to a multi-cycle data memory, plus the MEM/WB register.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RW      = RW_DEF,
    parameter int unsigned ALIGNCK = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_aluResult,
    input  logic [DW-1:0] ex_storeData,
    input  logic [DW-1:0] ex_nextPC,
    input  logic          ex_memRead,
    input  logic          ex_memWrite,
    input  logic          ex_enJAL,
    input  logic          ex_mem_to_reg,
    input  logic          ex_regWrite,
    input  logic [RW-1:0] ex_writeReg,
    input  logic          ex_halt,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          stall_out,
    output logic          wb_valid,
    output logic [DW-1:0] wb_aluResult,
    output logic [DW-1:0] wb_readData,
    output logic [DW-1:0] wb_nextPC,
    output logic          wb_enJAL,
    output logic          wb_mem_to_reg,
    output logic          wb_regWrite,
    output logic [RW-1:0] wb_writeReg,
    output logic          wb_halt,
    output logic          err
);

    localparam int unsigned LW = 3*DW + 3 + RW;

    logic [0:0]    state;
    logic          halted;
    logic          isMem;
    logic          mis;
    logic          acc;
    logic          issue;
    logic          busy;
    logic          complete;
    logic [DW-1:0] readDataNext;
    logic [LW-1:0] latchD;
    logic [LW-1:0] latchQ;

    assign mem_addr  = ex_aluResult;
    assign mem_wdata = ex_storeData;

    assign isMem = ex_memRead | ex_memWrite;
    assign mis   = (ALIGNCK != 0) & ex_aluResult[0] & isMem;
    assign acc   = ex_valid & isMem & ~halted & ~mis;

    // Request pulses only from IDLE; a simultaneous read+write is issued as a load.
    assign issue  = (state == IDLE) & acc & ~rst;
    assign mem_rd = issue & ex_memRead;
    assign mem_wr = issue & ex_memWrite & ~ex_memRead;

    assign busy      = ((state == IDLE) & acc) | (state == WAIT);
    assign stall_out = busy & ~mem_done;
    assign complete  = busy & mem_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (acc & ~mem_done) state <= WAIT;
                WAIT:    if (mem_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (ex_valid & ex_halt & ~halted & ~stall_out) halted <= 1'b1;
            if (ex_valid & mis & ~halted & ~stall_out) err <= 1'b1;
        end
    end

    assign wb_halt = halted;

    assign readDataNext = (complete & ex_memRead) ? mem_rdata : '0;

    // Misaligned ops retire as no-ops for the register file.
    assign latchD = {ex_aluResult, readDataNext, ex_nextPC, ex_enJAL,
                     ex_mem_to_reg & ~mis, ex_regWrite & ~mis, ex_writeReg};

    mem_wb_latch #(.W(LW)) wbLatch (
        .clk      (clk),
        .rst      (rst),
        .bubble   (stall_out),
        .validIn  (ex_valid & ~halted),
        .d        (latchD),
        .validOut (wb_valid),
        .q        (latchQ)
    );

    assign {wb_aluResult, wb_readData, wb_nextPC, wb_enJAL,
            wb_mem_to_reg, wb_regWrite, wb_writeReg} = latchQ;

endmodule
